// File: rtl/player_bullet_datapath.sv
// Player bullet: spawns at the player on fire, rises by SPEED per tick, ends on an
// enemy hit or on leaving the top of the screen, then waits out a cooldown before re-arming.
module player_bullet_datapath #(
    parameter int SPEED          = 3,
    parameter int SPAWN_Y        = 110,
    parameter int X_OFFSET       = 4,
    parameter int ENEMY_W        = 8,
    parameter int ENEMY_H        = 9,
    parameter int COOLDOWN_TICKS = 8
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       clear,
    input  logic       tick,
    input  logic       fire,
    input  logic [7:0] playerX,
    input  logic [7:0] enemyX,
    input  logic [6:0] enemyY,
    input  logic       enemyValid,
    output logic [7:0] bulletX,
    output logic [6:0] bulletY,
    output logic       bulletActive,
    output logic       hitPulse,
    output logic       topReached,
    output logic       ready
);

    localparam int CNT_W = $clog2(COOLDOWN_TICKS + 1);

    typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       bx_q, bx_d;
    logic [6:0]       by_q, by_d;
    logic             act_q, act_d;
    logic             hit_q, hit_d;
    logic             top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Widened compares so a box near the right/bottom edge does not wrap.
    logic [8:0] ex_lo, ex_hi, bx9;
    logic [7:0] ey_lo, ey_hi, by8;
    logic       hit_now, top_now;

    assign ex_lo   = {1'b0, enemyX};
    assign ex_hi   = ex_lo + 9'(ENEMY_W);
    assign bx9     = {1'b0, bx_q};
    assign ey_lo   = {1'b0, enemyY};
    assign ey_hi   = ey_lo + 8'(ENEMY_H);
    assign by8     = {1'b0, by_q};
    assign hit_now = enemyValid && (bx9 >= ex_lo) && (bx9 < ex_hi)
                                && (by8 >= ey_lo) && (by8 < ey_hi);
    assign top_now = (by_q < 7'(SPEED));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            bx_q    <= '0;
            by_q    <= '0;
            act_q   <= 1'b0;
            hit_q   <= 1'b0;
            top_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            act_q   <= act_d;
            hit_q   <= hit_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        act_d   = act_q;
        hit_d   = 1'b0;
        top_d   = 1'b0;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            bx_d    = '0;
            by_d    = '0;
            act_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        bx_d    = playerX + 8'(X_OFFSET);
                        by_d    = 7'(SPAWN_Y);
                        act_d   = 1'b1;
                        state_d = FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (tick) begin
                        if (hit_now) begin
                            hit_d   = 1'b1;
                            act_d   = 1'b0;
                            cnt_d   = CNT_W'(COOLDOWN_TICKS);
                            state_d = COOLDOWN;
                        end else if (top_now) begin
                            top_d   = 1'b1;
                            act_d   = 1'b0;
                            by_d    = '0;
                            cnt_d   = CNT_W'(COOLDOWN_TICKS);
                            state_d = COOLDOWN;
                        end else begin
                            by_d = by_q - 7'(SPEED);
                        end
                    end
                end
                COOLDOWN: begin
                    if (tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ready        = (state_q == IDLE);
        bulletX      = bx_q;
        bulletY      = by_q;
        bulletActive = act_q;
        hitPulse     = hit_q;
        topReached   = top_q;
    end

endmodule

// File: tb/tb_player_bullet_datapath.sv
// Bench for player_bullet_datapath: directed scenarios plus a randomized run, all
// checked against a rule-level model of the bullet's life cycle.
module tb_player_bullet_datapath;

    localparam int SPEED   = 3;
    localparam int SPAWN_Y = 110;
    localparam int XOFF    = 4;
    localparam int EW      = 8;
    localparam int EH      = 9;
    localparam int CD      = 8;

    logic       clk = 1'b0;
    logic       n_reset, clear, tick, fire, enemyValid;
    logic [7:0] playerX, enemyX;
    logic [6:0] enemyY;
    logic [7:0] bulletX;
    logic [6:0] bulletY;
    logic       bulletActive, hitPulse, topReached, ready;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = waiting to fire, 1 = bullet flying, 2 = cooling down.
    int m_phase, m_x, m_y, m_left;
    bit m_act, m_hit, m_top;

    player_bullet_datapath dut (
        .clk(clk), .n_reset(n_reset), .clear(clear), .tick(tick), .fire(fire),
        .playerX(playerX), .enemyX(enemyX), .enemyY(enemyY), .enemyValid(enemyValid),
        .bulletX(bulletX), .bulletY(bulletY), .bulletActive(bulletActive),
        .hitPulse(hitPulse), .topReached(topReached), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0; m_x = 0; m_y = 0; m_left = 0;
        m_act = 0; m_hit = 0; m_top = 0;
    endtask

    // Advance one clock: work out the model's next values from the inputs at the edge.
    task automatic step();
        int np = m_phase, nx = m_x, ny = m_y, nl = m_left;
        bit na = m_act, nh = 0, nt = 0;
        if (clear) begin
            np = 0; nx = 0; ny = 0; nl = 0; na = 0;
        end else if (m_phase == 0) begin
            if (fire) begin
                nx = (int'(playerX) + XOFF) % 256; ny = SPAWN_Y; na = 1; np = 1;
            end
        end else if (m_phase == 1) begin
            if (tick) begin
                if (enemyValid && m_x >= int'(enemyX) && m_x < int'(enemyX) + EW &&
                    m_y >= int'(enemyY) && m_y < int'(enemyY) + EH) begin
                    nh = 1; na = 0; nl = CD; np = 2;
                end else if (m_y < SPEED) begin
                    nt = 1; na = 0; ny = 0; nl = CD; np = 2;
                end else begin
                    ny = m_y - SPEED;
                end
            end
        end else if (tick) begin
            nl = m_left - 1;
            if (nl == 0) np = 0;
        end
        @(posedge clk);
        m_phase = np; m_x = nx; m_y = ny; m_left = nl; m_act = na; m_hit = nh; m_top = nt;
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1; step(); tick = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bulletX !== 8'd0 || bulletY !== 7'd0 || bulletActive !== 1'b0 ||
            hitPulse !== 1'b0 || topReached !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_initial: got x=%0d y=%0d act=%b hit=%b top=%b rdy=%b, want 0 0 0 0 0 1",
                     bulletX, bulletY, bulletActive, hitPulse, topReached, ready);
        end
        n_reset = 1'b1;
        playerX = 8'd20; fire = 1'b1; step(); fire = 1'b0;
        do_tick(); step(); do_tick();
        checks++;
        if (bulletActive !== 1'b1 || bulletY !== 7'd104) begin
            errors++;
            $display("FAIL reset_preflight: got act=%b y=%0d, want 1 104", bulletActive, bulletY);
        end
        #3 n_reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bulletX !== 8'd0 || bulletY !== 7'd0 || bulletActive !== 1'b0 ||
            hitPulse !== 1'b0 || topReached !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: got x=%0d y=%0d act=%b hit=%b top=%b rdy=%b, want 0 0 0 0 0 1",
                     bulletX, bulletY, bulletActive, hitPulse, topReached, ready);
        end
        #2 n_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) do_tick(); else step();
        end
        checks++;
        if (ready !== 1'b1 || bulletActive !== 1'b0 || bulletY !== 7'd0) begin
            errors++;
            $display("FAIL reset_idle_hold: got rdy=%b act=%b y=%0d, want 1 0 0", ready, bulletActive, bulletY);
        end
    endtask

    task automatic test_fire();
        playerX = 8'd50; fire = 1'b1; step(); fire = 1'b0;
        checks++;
        if (bulletX !== 8'd54 || bulletY !== 7'd110 || bulletActive !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL fire_spawn: got x=%0d y=%0d act=%b rdy=%b, want 54 110 1 0",
                     bulletX, bulletY, bulletActive, ready);
        end
        playerX = 8'd90; fire = 1'b1; step(); fire = 1'b0; step();
        checks++;
        if (bulletX !== 8'd54 || bulletY !== 7'd110 || bulletActive !== 1'b1) begin
            errors++;
            $display("FAIL fire_ignored: got x=%0d y=%0d act=%b, want 54 110 1", bulletX, bulletY, bulletActive);
        end
    endtask

    task automatic test_top_exit();
        enemyValid = 1'b0;
        for (int i = 0; i < 36; i++) begin do_tick(); step(); end
        checks++;
        if (bulletY !== 7'd2 || bulletActive !== 1'b1) begin
            errors++;
            $display("FAIL top_after36: got y=%0d act=%b, want 2 1", bulletY, bulletActive);
        end
        do_tick();
        checks++;
        if (topReached !== 1'b1 || hitPulse !== 1'b0 || bulletActive !== 1'b0 || bulletY !== 7'd0) begin
            errors++;
            $display("FAIL top_pulse: got top=%b hit=%b act=%b y=%0d, want 1 0 0 0",
                     topReached, hitPulse, bulletActive, bulletY);
        end
        step();
        checks++;
        if (topReached !== 1'b0) begin
            errors++;
            $display("FAIL top_pulse_width: got top=%b, want 0", topReached);
        end
        for (int i = 0; i < CD - 1; i++) begin do_tick(); step(); end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL cooldown_7: got rdy=%b, want 0", ready);
        end
        do_tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL cooldown_8: got rdy=%b, want 1", ready);
        end
    endtask

    task automatic test_hit();
        playerX = 8'd50; enemyX = 8'd50; enemyY = 7'd100; enemyValid = 1'b1;
        fire = 1'b1; step(); fire = 1'b0;
        do_tick();
        checks++;
        if (hitPulse !== 1'b0 || bulletY !== 7'd107 || bulletActive !== 1'b1) begin
            errors++;
            $display("FAIL hit_tick1: got hit=%b y=%0d act=%b, want 0 107 1", hitPulse, bulletY, bulletActive);
        end
        step(); do_tick();
        checks++;
        if (hitPulse !== 1'b1 || topReached !== 1'b0 || bulletY !== 7'd107 ||
            bulletX !== 8'd54 || bulletActive !== 1'b0) begin
            errors++;
            $display("FAIL hit_tick2: got hit=%b top=%b x=%0d y=%0d act=%b, want 1 0 54 107 0",
                     hitPulse, topReached, bulletX, bulletY, bulletActive);
        end
        step();
        checks++;
        if (hitPulse !== 1'b0 || bulletY !== 7'd107) begin
            errors++;
            $display("FAIL hit_pulse_width: got hit=%b y=%0d, want 0 107", hitPulse, bulletY);
        end
        for (int i = 0; i < CD; i++) begin do_tick(); step(); end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL hit_cooldown_done: got rdy=%b, want 1", ready);
        end
    endtask

    task automatic test_edges();
        playerX = 8'd250; enemyX = 8'd250; enemyY = 7'd105; enemyValid = 1'b1;
        fire = 1'b1; step(); fire = 1'b0;
        checks++;
        if (bulletX !== 8'd254) begin
            errors++;
            $display("FAIL edge_x254: got x=%0d, want 254", bulletX);
        end
        do_tick();
        checks++;
        if (hitPulse !== 1'b1 || bulletActive !== 1'b0) begin
            errors++;
            $display("FAIL edge_wide_hit: got hit=%b act=%b, want 1 0", hitPulse, bulletActive);
        end
        clear = 1'b1; step(); clear = 1'b0;
        playerX = 8'd50; enemyX = 8'd46;
        fire = 1'b1; step(); fire = 1'b0;
        do_tick();
        checks++;
        if (hitPulse !== 1'b0 || bulletActive !== 1'b1 || bulletY !== 7'd107) begin
            errors++;
            $display("FAIL edge_right_excl: got hit=%b act=%b y=%0d, want 0 1 107", hitPulse, bulletActive, bulletY);
        end
        clear = 1'b1; step(); clear = 1'b0;
        playerX = 8'd253; fire = 1'b1; step(); fire = 1'b0;
        checks++;
        if (bulletX !== 8'd1 || bulletActive !== 1'b1) begin
            errors++;
            $display("FAIL edge_wrap: got x=%0d act=%b, want 1 1", bulletX, bulletActive);
        end
        clear = 1'b1; step(); clear = 1'b0;
        playerX = 8'd50; enemyX = 8'd50; enemyValid = 1'b0;
        fire = 1'b1; step(); fire = 1'b0;
        do_tick();
        checks++;
        if (hitPulse !== 1'b0 || bulletActive !== 1'b1 || bulletY !== 7'd107) begin
            errors++;
            $display("FAIL edge_invalid_mask: got hit=%b act=%b y=%0d, want 0 1 107", hitPulse, bulletActive, bulletY);
        end
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic test_clear();
        playerX = 8'd30; enemyValid = 1'b0;
        fire = 1'b1; step(); fire = 1'b0;
        do_tick(); step();
        clear = 1'b1; tick = 1'b1; step(); clear = 1'b0; tick = 1'b0;
        checks++;
        if (ready !== 1'b1 || bulletActive !== 1'b0 || hitPulse !== 1'b0 ||
            topReached !== 1'b0 || bulletX !== 8'd0 || bulletY !== 7'd0) begin
            errors++;
            $display("FAIL clear_flight: got rdy=%b act=%b hit=%b top=%b x=%0d y=%0d, want 1 0 0 0 0 0",
                     ready, bulletActive, hitPulse, topReached, bulletX, bulletY);
        end
        playerX = 8'd50; enemyX = 8'd50; enemyY = 7'd105; enemyValid = 1'b1;
        fire = 1'b1; step(); fire = 1'b0;
        do_tick();
        for (int i = 0; i < 3; i++) begin step(); do_tick(); end
        checks++;
        if (ready !== 1'b0 || m_left != 5) begin
            errors++;
            $display("FAIL clear_cd_setup: got rdy=%b left=%0d, want 0 5", ready, m_left);
        end
        clear = 1'b1; step(); clear = 1'b0;
        checks++;
        if (ready !== 1'b1 || bulletActive !== 1'b0) begin
            errors++;
            $display("FAIL clear_cooldown: got rdy=%b act=%b, want 1 0", ready, bulletActive);
        end
        playerX = 8'd10; fire = 1'b1; step(); fire = 1'b0;
        checks++;
        if (bulletActive !== 1'b1 || bulletX !== 8'd14 || bulletY !== 7'd110) begin
            errors++;
            $display("FAIL clear_refire: got act=%b x=%0d y=%0d, want 1 14 110", bulletActive, bulletX, bulletY);
        end
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            fire       = ($urandom % 5 == 0);
            tick       = ($urandom % 3 == 0);
            clear      = ($urandom % 300 == 0);
            playerX    = 8'($urandom);
            enemyValid = ($urandom % 4 != 0);
            enemyX     = (n % 2 == 0) ? 8'(int'(bulletX) - int'($urandom_range(0, 9))) : 8'($urandom);
            enemyY     = 7'($urandom);
            step();
            checks++;
            if (bulletX !== 8'(m_x) || bulletY !== 7'(m_y) || bulletActive !== m_act ||
                hitPulse !== m_hit || topReached !== m_top || ready !== (m_phase == 0)) begin
                errors++;
                $display("FAIL random_cycle %0d: got x=%0d y=%0d act=%b hit=%b top=%b rdy=%b, want %0d %0d %b %b %b %b",
                         n, bulletX, bulletY, bulletActive, hitPulse, topReached, ready,
                         m_x, m_y, m_act, m_hit, m_top, (m_phase == 0));
            end
            checks++;
            if (hitPulse === 1'b1 && topReached === 1'b1) begin
                errors++;
                $display("FAIL random_pulse_excl %0d: got hit=1 top=1, want at most one", n);
            end
        end
        fire = 1'b0; tick = 1'b0; clear = 1'b0;
    endtask

    initial begin
        n_reset = 1'b0; clear = 1'b0; tick = 1'b0; fire = 1'b0;
        playerX = 8'd0; enemyX = 8'd0; enemyY = 7'd0; enemyValid = 1'b0;
        model_reset();
        #12;
        test_reset();
        test_fire();
        test_top_exit();
        test_hit();
        test_edges();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_bullet_datapath.md
Name: player_bullet_datapath

Overview:
- Datapath/FSM for the player's single bullet. It is the upward-moving counterpart to the enemy datapath.
- Spawns a bullet at the player's X on fire, then moves it up by SPEED each position-update tick.
- Detects a hit against one enemy bounding box, and pulses hit or top-reached when flight ends.
- Enforces a cooldown before the next shot. Sits between the game control FSM and the draw/score logic.

Parameters:
SPEED, 3, pixels the bullet rises per update tick (1..7)
SPAWN_Y, 110, initial bullet Y on fire (7-bit)
X_OFFSET, 4, added to playerX for bullet X (centres on sprite)
ENEMY_W, 8, enemy hitbox width in pixels
ENEMY_H, 9, enemy hitbox height in pixels
COOLDOWN_TICKS, 8, update ticks spent in cooldown after flight ends (>=1)

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
clear  in  1  synchronous abort (game reset state); kills bullet, returns to idle
tick  in  1  position-update strobe, one cycle wide
fire  in  1  fire request, level-sampled
playerX  in  8  player sprite X
enemyX  in  8  enemy X (top-left)
enemyY  in  7  enemy Y (top-left)
enemyValid  in  1  enemy present; hits are masked when 0
bulletX  out  8  bullet X
bulletY  out  7  bullet Y
bulletActive  out  1  bullet in flight (draw enable)
hitPulse  out  1  one-cycle pulse on hit
topReached  out  1  one-cycle pulse on leaving the top of the screen
ready  out  1  combinational, 1 iff state==IDLE

Behaviour:
- States: IDLE, FLIGHT, COOLDOWN.
- Priority: n_reset > clear > tick/fire handling.
- n_reset low (async): state=IDLE, bulletX=0, bulletY=0, bulletActive=0, hitPulse=0, topReached=0, cooldown count=0.
- clear=1 at clk edge: same values as reset, synchronous. No pulse is generated, and it overrides a simultaneous tick/fire.
- hitPulse and topReached default to 0 every cycle. Each is high for exactly the one cycle after the deciding edge, and they are never high together.
- IDLE:
  - fire=1 at edge → bulletX=(playerX+X_OFFSET) mod 256, bulletY=SPAWN_Y, bulletActive=1, state=FLIGHT. Latency is 1 cycle.
  - tick has no effect in IDLE. fire and tick in the same cycle → spawn only.
- FLIGHT:
  - fire is ignored (no queuing). The position is evaluated only on a tick edge, using the current bulletX/bulletY and the current enemy inputs.
  - Hit condition, with 9-bit X and 8-bit Y arithmetic so there is no wrap: enemyValid && enemyX<=bulletX<enemyX+ENEMY_W && enemyY<=bulletY<enemyY+ENEMY_H.
  - Hit (priority over top) → hitPulse, bulletActive=0, bulletX/bulletY held, load cooldown, state=COOLDOWN.
  - Else if bulletY<SPEED → topReached, bulletActive=0, bulletY=0, load cooldown, state=COOLDOWN.
  - Else → bulletY=bulletY−SPEED.
- COOLDOWN:
  - The counter is loaded with COOLDOWN_TICKS on entry and decrements on each tick.
  - On the tick that takes the count from 1 to 0, state=IDLE. So IDLE is entered on the COOLDOWN_TICKS-th tick after flight end.
  - fire is ignored.
- The enemy box moving between ticks is irrelevant; only values sampled at tick edges count.

Test Plan:
1. Reset sequence: assert n_reset low mid-clock with the bullet in flight → all outputs 0 immediately, ready=1; release, and the idle state holds without fire.
2. Fire: playerX=50, fire for 1 cycle → next cycle bulletX=54, bulletY=110, bulletActive=1, ready=0; a second fire pulse during FLIGHT changes nothing.
3. Top exit: enemyValid=0 → after 36 ticks bulletY=2; 37th tick → topReached 1 cycle, bulletActive=0, bulletY=0. Ready=1 after exactly 8 further ticks, not 7.
4. Hit: enemyX=50, enemyY=100, enemyValid=1, bullet at (54,110) → tick 1: no hit, Y=107; tick 2: hitPulse 1 cycle, bulletY held 107, bulletActive=0, topReached=0.
5. Edges: enemyX=250, playerX=250 → bulletX=254, hit at Y in the enemy box (9-bit compare, 254<258). enemyX=46 → bulletX=54 not hit (54 = 46+8). playerX=253 → bulletX=1 (wrap). enemyValid=0 over the box → no hit.
6. clear: assert clear with tick in FLIGHT → next cycle IDLE, bulletActive=0, no pulses. Assert clear in COOLDOWN with count=5 → IDLE, and fire on the next cycle spawns normally.
